// File: rtl/jtgng_objline_draw.sv
// Sprite line-buffer reader: walks the 32 object slots on every HINIT, fetches two
// 8-pixel ROM words per visible object and writes its opaque pixels to the line buffer.
module jtgng_objline_draw #(
    parameter int unsigned ROM_AW  = 15,
    parameter logic [7:0]  HOFFSET = 8'd0,
    parameter logic [7:0]  EMPTY   = 8'hF8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              HINIT,
    input  logic [7:0]        VF,
    input  logic              flip,
    input  logic [7:0]        objbuf_data,
    output logic [4:0]        objcnt,
    output logic [3:0]        pxlcnt,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_cs,
    input  logic              rom_ok,
    input  logic [31:0]       rom_data,
    output logic [8:0]        buf_addr,
    output logic [7:0]        buf_data,
    output logic              buf_we,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        RDY,
        RDREST,
        FETCH,
        DRAW,
        NEXT
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  step;          // read sub-step inside RDY / RDREST
    logic [2:0]  pix;           // pixel index inside the current half
    logic        half;          // screen-order half being fetched/drawn
    logic [7:0]  code_lo;
    logic [1:0]  code_hi;
    logic [1:0]  pal;
    logic        vflip, hflip, xmsb;
    logic [7:0]  xpos;
    logic [3:0]  row;
    logic [31:0] pix_data;

    logic [7:0]        row_full;
    logic              y_skip;
    logic              vf, hf;
    logic [3:0]        row_eff;
    logic [8:0]        x9, base_x;
    logic [ROM_AW-1:0] fetch_addr;
    logic [2:0]        nib_sel;
    logic [3:0]        nib;
    logic              rom_hit;

    always_comb begin
        row_full   = VF - objbuf_data;
        y_skip     = (objbuf_data == EMPTY) || (row_full[7:4] != 4'd0);
        vf         = vflip ^ flip;
        hf         = hflip ^ flip;
        row_eff    = vf ? ~row : row;
        x9         = {xmsb, xpos};
        base_x     = (flip ? (9'd240 - x9) : x9) + {1'b0, HOFFSET};
        fetch_addr = ROM_AW'({code_hi, code_lo, row_eff, half ^ hf});
        // Horizontal flip mirrors both the half order and the nibble order.
        nib_sel    = hf ? ~pix : pix;
        nib        = 4'(pix_data >> {nib_sel, 2'b00});
        rom_hit    = rom_cs && rom_ok;
    end

    always_comb begin
        // NOTE: next state defaults to the current one before the case, so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            RDY:     if (step == 2'd1) state_nxt = y_skip ? NEXT : RDREST;
            RDREST:  if (step == 2'd3) state_nxt = FETCH;
            FETCH:   if (rom_hit) state_nxt = DRAW;
            DRAW:    if (pix == 3'd7) state_nxt = half ? NEXT : FETCH;
            NEXT:    state_nxt = (objcnt == 5'd31) ? IDLE : RDY;
            default: state_nxt = IDLE;
        endcase
        if (HINIT) state_nxt = RDY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (cen) state <= state_nxt;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            objcnt   <= 5'd0;
            pxlcnt   <= 4'd0;
            rom_addr <= '0;
            rom_cs   <= 1'b0;
            buf_addr <= 9'd0;
            buf_data <= 8'd0;
            buf_we   <= 1'b0;
            done     <= 1'b1;
            step     <= 2'd0;
            pix      <= 3'd0;
            half     <= 1'b0;
            code_lo  <= 8'd0;
            code_hi  <= 2'd0;
            pal      <= 2'd0;
            vflip    <= 1'b0;
            hflip    <= 1'b0;
            xmsb     <= 1'b0;
            xpos     <= 8'd0;
            row      <= 4'd0;
            pix_data <= 32'd0;
        end else if (cen) begin
            buf_we <= 1'b0;
            if (HINIT) begin
                objcnt <= 5'd0;
                pxlcnt <= 4'd2;
                step   <= 2'd0;
                rom_cs <= 1'b0;
                done   <= 1'b0;
            end else begin
                case (state)
                    RDY: begin
                        // Y byte arrives on the second cycle after pxlcnt was set.
                        if (step == 2'd1) begin
                            row    <= row_full[3:0];
                            pxlcnt <= 4'd0;
                            step   <= 2'd0;
                        end else begin
                            step <= step + 2'd1;
                        end
                    end
                    RDREST: begin
                        step <= step + 2'd1;
                        case (step)
                            2'd0: pxlcnt <= 4'd1;
                            2'd1: begin
                                code_lo <= objbuf_data;
                                pxlcnt  <= 4'd3;
                            end
                            2'd2: begin
                                code_hi <= objbuf_data[7:6];
                                pal     <= objbuf_data[5:4];
                                vflip   <= objbuf_data[3];
                                hflip   <= objbuf_data[2];
                                xmsb    <= objbuf_data[0];
                            end
                            default: begin
                                xpos <= objbuf_data;
                                half <= 1'b0;
                            end
                        endcase
                    end
                    FETCH: begin
                        // rom_cs must already be high, so a stale rom_ok cannot be taken.
                        if (rom_hit) begin
                            pix_data <= rom_data;
                            rom_cs   <= 1'b0;
                            pix      <= 3'd0;
                        end else begin
                            rom_cs   <= 1'b1;
                            rom_addr <= fetch_addr;
                        end
                    end
                    DRAW: begin
                        buf_addr <= base_x + {5'd0, half, pix};
                        buf_data <= {2'b00, pal, nib};
                        buf_we   <= (nib != 4'hF);
                        pix      <= pix + 3'd1;
                        if (pix == 3'd7) half <= ~half;
                    end
                    NEXT: begin
                        if (objcnt == 5'd31) begin
                            done <= 1'b1;
                        end else begin
                            objcnt <= objcnt + 5'd1;
                            pxlcnt <= 4'd2;
                            step   <= 2'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtgng_objline_draw.sv
// Bench for jtgng_objline_draw: directed corner cases plus random lines checked against
// a pixel-level model of how a line of sprites should look.
module tb_jtgng_objline_draw;

    localparam int         ROM_AW  = 15;
    localparam logic [7:0] HOFFSET = 8'd0;
    localparam logic [7:0] EMPTY   = 8'hF8;

    logic              clk = 1'b0;
    logic              cen = 1'b0;
    logic              rst;
    logic              HINIT;
    logic [7:0]        VF;
    logic              flip;
    logic [7:0]        objbuf_data;
    logic [4:0]        objcnt;
    logic [3:0]        pxlcnt;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_cs;
    logic              rom_ok;
    logic [31:0]       rom_data;
    logic [8:0]        buf_addr;
    logic [7:0]        buf_data;
    logic              buf_we;
    logic              done;

    jtgng_objline_draw #(.ROM_AW(ROM_AW), .HOFFSET(HOFFSET), .EMPTY(EMPTY)) dut (
        .clk(clk), .rst(rst), .cen(cen), .HINIT(HINIT), .VF(VF), .flip(flip),
        .objbuf_data(objbuf_data), .objcnt(objcnt), .pxlcnt(pxlcnt),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we), .done(done)
    );

    logic [7:0]        objmem  [128];
    logic [31:0]       rom_mem [32768];
    int                rom_lat   = 0;
    logic              rom_force = 1'b0;
    int                rom_wait  = 0;
    logic [ROM_AW-1:0] rom_last  = '0;

    logic [7:0]        linebuf [512];
    int                n_writes;
    logic [ROM_AW-1:0] fetch_q [$];
    logic [7:0]        exp_buf [512];
    int                exp_writes;
    logic [ROM_AW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cen <= ~cen;

    // Object buffer with one cen-cycle read latency.
    always @(posedge clk) if (cen) objbuf_data <= objmem[{objcnt, pxlcnt[1:0]}];

    // ROM answers rom_lat clocks after a stable request.
    always @(posedge clk) begin
        rom_last <= rom_addr;
        if (!rom_cs || rom_addr != rom_last) rom_wait <= 0;
        else if (rom_wait < 1000)            rom_wait <= rom_wait + 1;
    end
    assign rom_ok   = rom_force || (rom_cs && (rom_wait >= rom_lat));
    assign rom_data = rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // NOTE: outputs are sampled on the falling edge, where cen and DUT outputs are stable.
    task automatic tick();
        @(negedge clk);
        if (cen && buf_we) begin
            linebuf[buf_addr] = buf_data;
            n_writes++;
        end
        if (cen && rom_cs && rom_ok) fetch_q.push_back(rom_addr);
    endtask

    // Advance past exactly one active cen edge.
    task automatic step();
        do tick(); while (cen !== 1'b0);
    endtask

    task automatic hinit_pulse();
        if (cen !== 1'b1) tick();
        HINIT = 1'b1;
        tick();
        HINIT = 1'b0;
    endtask

    task automatic start_line(input string tag);
        for (int i = 0; i < 512; i++) linebuf[i] = 8'hFF;
        n_writes = 0;
        fetch_q.delete();
        hinit_pulse();
        check({tag, "_busy"}, done, 1'b0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, done, 1'b1);
    endtask

    function automatic logic [31:0] fetch_at(input int i);
        if (i < fetch_q.size()) return 32'(fetch_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // What the line should look like: sprites painted in slot order, each a 16-pixel strip.
    task automatic build_expected();
        for (int i = 0; i < 512; i++) exp_buf[i] = 8'hFF;
        exp_writes = 0;
        exp_q.delete();
        for (int s = 0; s < 32; s++) begin
            int y, attr, row, code, x, vfl, hfl, r, base, word0;
            y    = int'(objmem[s*4+2]);
            attr = int'(objmem[s*4+1]);
            if (y == int'(EMPTY)) continue;
            row = (int'(VF) - y) & 255;
            if (row >= 16) continue;
            code  = ((attr >> 6) << 8) | int'(objmem[s*4]);
            x     = ((attr & 1) << 8) | int'(objmem[s*4+3]);
            vfl   = ((attr >> 3) & 1) ^ int'(flip);
            hfl   = ((attr >> 2) & 1) ^ int'(flip);
            r     = (vfl != 0) ? 15 - row : row;
            base  = ((flip ? 240 - x : x) + int'(HOFFSET)) & 511;
            word0 = code * 32 + r * 2;
            exp_q.push_back(ROM_AW'(word0 + hfl));
            exp_q.push_back(ROM_AW'(word0 + (1 - hfl)));
            for (int px = 0; px < 16; px++) begin
                int p, nib;
                p   = (hfl != 0) ? 15 - px : px;
                nib = int'(rom_mem[word0 + p / 8] >> (4 * (p % 8))) & 15;
                if (nib != 15) begin
                    exp_buf[(base + px) & 511] = 8'((((attr >> 4) & 3) << 4) | nib);
                    exp_writes++;
                end
            end
        end
    endtask

    task automatic compare_line(input string tag);
        int bad = 0;
        int qbad = 0;
        build_expected();
        for (int i = 0; i < 512; i++) if (linebuf[i] !== exp_buf[i]) bad++;
        check({tag, "_pixels"}, bad, 0);
        check({tag, "_writes"}, n_writes, exp_writes);
        check({tag, "_nfetch"}, fetch_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) if (fetch_at(i) !== 32'(exp_q[i])) qbad++;
        check({tag, "_fetchaddr"}, qbad, 0);
    endtask

    task automatic clear_slots();
        for (int s = 0; s < 32; s++) begin
            objmem[s*4]   = 8'($urandom);
            objmem[s*4+1] = 8'($urandom);
            objmem[s*4+2] = EMPTY;
            objmem[s*4+3] = 8'($urandom);
        end
    endtask

    task automatic set_slot(input int s, input logic [7:0] code, input logic [7:0] attr,
                            input logic [7:0] y, input logic [7:0] x);
        objmem[s*4]   = code;
        objmem[s*4+1] = attr;
        objmem[s*4+2] = y;
        objmem[s*4+3] = x;
    endtask

    initial begin
        int snap_w, snap_f, n;
        rst   = 1'b1;
        HINIT = 1'b0;
        VF    = 8'h00;
        flip  = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            logic [31:0] w;
            w = $urandom;
            for (int j = 0; j < 8; j++) if ($urandom_range(0, 4) == 0) w[j*4 +: 4] = 4'hF;
            rom_mem[i] = w;
        end
        clear_slots();

        // Reset state
        repeat (4) tick();
        check("rst_objcnt", objcnt, 5'd0);
        check("rst_pxlcnt", pxlcnt, 4'd0);
        check("rst_rom_addr", rom_addr, 15'd0);
        check("rst_rom_cs", rom_cs, 1'b0);
        check("rst_buf_addr", buf_addr, 9'd0);
        check("rst_buf_data", buf_data, 8'd0);
        check("rst_buf_we", buf_we, 1'b0);
        check("rst_done", done, 1'b1);
        rst = 1'b0;
        repeat (4) tick();

        // All slots empty: no fetches, no writes
        VF = 8'h40;
        start_line("empty");
        check("empty_pxlcnt", pxlcnt, 4'd2);
        wait_done("empty", 400);
        compare_line("empty");
        check("empty_no_writes", n_writes, 0);

        // Single sprite in slot 5, no flip
        set_slot(5, 8'd12, 8'h10, 8'h40, 8'h20);
        VF = 8'h43;
        rom_mem[15'h186] = 32'h7654_3210;
        rom_mem[15'h187] = 32'h5EDC_BA98;
        start_line("plain");
        wait_done("plain", 4000);
        check("plain_fetch0", fetch_at(0), 32'h186);
        check("plain_fetch1", fetch_at(1), 32'h187);
        check("plain_px20", linebuf[9'h020], 8'h10);
        check("plain_px27", linebuf[9'h027], 8'h17);
        check("plain_px28", linebuf[9'h028], 8'h18);
        check("plain_px2f", linebuf[9'h02F], 8'h15);
        compare_line("plain");

        // Same sprite mirrored horizontally
        set_slot(5, 8'd12, 8'h14, 8'h40, 8'h20);
        start_line("hflip");
        wait_done("hflip", 4000);
        check("hflip_fetch0", fetch_at(0), 32'h187);
        check("hflip_px20", linebuf[9'h020], 8'h15);
        check("hflip_px27", linebuf[9'h027], 8'h18);
        check("hflip_px2f", linebuf[9'h02F], 8'h10);
        compare_line("hflip");

        // Fully transparent sprite in slot 5, visible one in slot 6
        set_slot(5, 8'd12, 8'h10, 8'h40, 8'h20);
        set_slot(6, 8'h21, 8'h20, 8'h42, 8'h80);
        rom_mem[15'h186] = 32'hFFFF_FFFF;
        rom_mem[15'h187] = 32'hFFFF_FFFF;
        rom_mem[15'h422] = 32'h0123_4567;
        rom_mem[15'h423] = 32'h89AB_CDE0;
        start_line("transp");
        wait_done("transp", 4000);
        check("transp_px20", linebuf[9'h020], 8'hFF);
        check("transp_px80", linebuf[9'h080], 8'h27);
        check("transp_nwrites", n_writes, 16);
        compare_line("transp");

        // HINIT while a ROM request is pending; a stray rom_ok afterwards is ignored
        rom_mem[15'h186] = 32'h7654_3210;
        rom_mem[15'h187] = 32'h5EDC_BA98;
        rom_lat = 100000;
        start_line("abort1");
        n = 0;
        while (rom_cs !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("abort_wait_cs", rom_cs, 1'b1);
        start_line("abort2");
        check("abort_rom_cs", rom_cs, 1'b0);
        check("abort_objcnt", objcnt, 5'd0);
        check("abort_pxlcnt", pxlcnt, 4'd2);
        rom_force = 1'b1;
        repeat (2) tick();
        rom_force = 1'b0;
        rom_lat   = 0;
        wait_done("abort", 4000);
        compare_line("abort");

        // Asynchronous reset in the middle of drawing
        rom_lat = 1;
        start_line("rstdraw");
        n = 0;
        while (buf_we !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("rstdraw_we_seen", buf_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rstdraw_rom_cs", rom_cs, 1'b0);
        check("rstdraw_buf_we", buf_we, 1'b0);
        check("rstdraw_done", done, 1'b1);
        repeat (2) tick();
        rst    = 1'b0;
        snap_w = n_writes;
        snap_f = fetch_q.size();
        repeat (100) tick();
        check("rstdraw_quiet_w", n_writes, snap_w);
        check("rstdraw_quiet_f", fetch_q.size(), snap_f);
        check("rstdraw_idle_done", done, 1'b1);
        start_line("after_rst");
        wait_done("after_rst", 4000);
        compare_line("after_rst");

        // Random lines
        for (int t = 0; t < 8; t++) begin
            VF      = 8'($urandom);
            flip    = 1'($urandom);
            rom_lat = $urandom_range(0, 3);
            for (int s = 0; s < 32; s++) begin
                logic [7:0] y;
                if ($urandom_range(0, 3) == 0) y = EMPTY;
                else                           y = VF - 8'($urandom_range(0, 20));
                set_slot(s, 8'($urandom), 8'($urandom), y, 8'($urandom_range(0, 80)));
            end
            start_line($sformatf("rand%0d", t));
            wait_done($sformatf("rand%0d", t), 8000);
            compare_line($sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
